// File: rtl/pencoder_arb.sv
// pencoder_arb -- registered priority encoder with request capture and a
// valid/ready output handshake.
//
// Pulsed requests on N lines are captured into a pending register. One
// encoded index at a time is presented to a downstream consumer. The
// highest-priority pending index wins. Priority is searched downward from a
// pointer, wrapping modulo N.
//
// Configuration macro: PENCODER_RR_EN
//   undefined : fixed priority. The pointer is constant N-1, so the highest
//               set index always wins.
//   defined   : rotating priority. Accepting index k moves the pointer to
//               (k-1) mod N, which makes k the lowest priority.
//
// Parameters:
//   N      number of request lines (2..64)
//   IDX_W  width of the encoded index (>= 1, >= $clog2(N))
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   req        request lines; a one-cycle pulse is captured
//   out_valid  out_idx holds a pending request
//   out_ready  consumer accepts out_idx when out_valid & out_ready
//   out_idx    encoded index of the granted request
//   pending    pending-request register
//   busy       out_valid | (|pending), registered
module pencoder_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             busy
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     pending_next_s;
  logic [IDX_W-1:0] out_idx_r;
  logic [IDX_W-1:0] idx_next_s;
  logic             out_valid_r;
  logic             busy_r;
  logic [N-1:0]     clr_s;
  logic [N-1:0]     rem_s;
  logic             accept_s;
  logic [PTR_W-1:0] ptr_cur_s;   // pointer in effect this cycle
  logic [PTR_W-1:0] ptr_acc_s;   // pointer in effect after an accept

  // Winner of v: first set bit searching p, p-1, ..., 0, N-1, ..., p+1.
  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v,
                                            input logic [PTR_W-1:0] p);
    logic [IDX_W-1:0] r;
    logic             found;
    int               j;
    r     = {IDX_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(p) - i;
      if (j < 0) begin
        j = j + N;
      end else begin
        j = j;
      end
      if (!found && v[j]) begin
        r     = IDX_W'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // One-hot N-bit vector for index k.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++) begin
      oh[i] = (int'(k) == i) ? 1'b1 : 1'b0;
    end
    return oh;
  endfunction

  assign accept_s = out_valid_r & out_ready;

`ifdef PENCODER_RR_EN
  logic [PTR_W-1:0] ptr_r;

  // (k-1) mod N for the accepted index k.
  function automatic logic [PTR_W-1:0] dec_mod(input logic [IDX_W-1:0] k);
    logic [PTR_W-1:0] r;
    if (int'(k) == 0) begin
      r = PTR_RST;
    end else begin
      r = PTR_W'(int'(k) - 1);
    end
    return r;
  endfunction

  assign ptr_cur_s = ptr_r;
  assign ptr_acc_s = dec_mod(out_idx_r);

  // Rotating pointer: the accepted index becomes lowest priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= PTR_RST;
    end else if (accept_s) begin
      ptr_r <= ptr_acc_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign ptr_cur_s = PTR_RST;
  assign ptr_acc_s = PTR_RST;
`endif

  // Next-state, next index and pending update.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = out_idx_r;
    clr_s        = {N{1'b0}};
    rem_s        = {N{1'b0}};
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          idx_next_s   = pick(pending_r, ptr_cur_s);
          state_next_s = HOLD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          clr_s = onehot(out_idx_r);
          // New requests are deliberately excluded here; they are seen
          // the following cycle.
          rem_s = pending_r & ~clr_s;
          if (|rem_s) begin
            idx_next_s   = pick(rem_s, ptr_acc_s);
            state_next_s = HOLD;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    // A request on the line being accepted re-arms it.
    pending_next_s = (pending_r & ~clr_s) | req;
  end

  // State, pending and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pending_r   <= {N{1'b0}};
      out_idx_r   <= {IDX_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pending_r   <= pending_next_s;
      out_idx_r   <= idx_next_s;
      out_valid_r <= (state_next_s == HOLD);
      busy_r      <= (state_next_s == HOLD) | (|pending_next_s);
    end
  end

  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign pending   = pending_r;
  assign busy      = busy_r;

endmodule
